fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the 64-bit IF/ID register. It owns the PC and issues one-outstanding requests to instruction memory. It produces the IF/ID word {pc, instr} plus the IF/ID capture enable, and handles hazard stalls and branch/jump redirects from EX by injecting a NOP (flush).

---
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus and IF/ID write port of the fetch stage.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [63:0] ifid_data;
  logic        ifid_ce;

  // Fetch-unit side: drives the memory request and the IF/ID write port.
  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata,
    output ifid_data,
    output ifid_ce
  );

  // Memory / IF/ID side.
  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata,
    input  ifid_data,
    input  ifid_ce
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one imem request outstanding and
// writes {pc, instr} into IF/ID. A stalled response is parked in hold_q; a
// redirect flushes IF/ID with a NOP and, if a response is still in flight,
// waits in DROP so the stale word is discarded.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | after reset, no request yet
//   FETCH | request for pc_q outstanding on imem
//   HOLD  | response captured in hold_q, waiting for stall to clear
//   DROP  | redirected while a response is in flight; discard it
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] redirect_pc_aligned;
  logic [31:0] pc_inc;

  assign redirect_pc_aligned = {redirect_pc[31:2], 2'b00};
  assign pc_inc              = pc_q + 32'd4;  // wraps modulo 2^32

  // State, PC and held-instruction registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      hold_q  <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
    end
  end

  // Next state, next PC and held-instruction capture; redirect beats stall.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc_aligned;
          state_d = bus.imem_rvalid ? FETCH : DROP;
        end else if (bus.imem_rvalid && !stall) begin
          pc_d = pc_inc;
        end else if (bus.imem_rvalid && stall) begin
          hold_d  = bus.imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc_aligned;
          state_d = FETCH;
        end else if (!stall) begin
          pc_d    = pc_inc;
          state_d = FETCH;
        end
      end
      DROP: begin
        if (redirect_valid) pc_d = redirect_pc_aligned;
        if (bus.imem_rvalid) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory request and IF/ID write port; quiet while reset is asserted.
  always_comb begin
    bus.imem_req  = 1'b0;
    bus.imem_addr = pc_q;
    bus.ifid_ce   = 1'b0;
    bus.ifid_data = {pc_q, NOP_INSTR};
    if (rst_n) begin
      unique case (state_q)
        IDLE: ;
        FETCH: begin
          bus.imem_req = 1'b1;
          if (redirect_valid) begin
            bus.ifid_ce = 1'b1;
          end else if (bus.imem_rvalid && !stall) begin
            bus.ifid_ce   = 1'b1;
            bus.ifid_data = {pc_q, bus.imem_rdata};
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            bus.ifid_ce = 1'b1;
          end else if (!stall) begin
            bus.ifid_ce   = 1'b1;
            bus.ifid_data = {pc_q, hold_q};
          end
        end
        DROP: begin
          if (redirect_valid) bus.ifid_ce = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: inputs change after the falling edge and
// outputs are checked 1 ns later, well away from the rising edge.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  int          n_checks;
  int          n_fail;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Apply one cycle's inputs and let the combinational outputs settle.
  task automatic drive(input logic st, input logic rv, input logic [31:0] rpc,
                       input logic mv, input logic [31:0] md);
    stall           = st;
    redirect_valid  = rv;
    redirect_pc     = rpc;
    bus.imem_rvalid = mv;
    bus.imem_rdata  = md;
    #1;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    @(negedge clk);

    // reset held two cycles, then the IDLE cycle
    drive(0, 0, 0, 0, 0);
    chk("rst0_req", bus.imem_req, 0);
    chk("rst0_ce", bus.ifid_ce, 0);
    cyc();
    chk("rst1_req", bus.imem_req, 0);
    chk("rst1_ce", bus.ifid_ce, 0);
    chk("rst1_data", bus.ifid_data, {32'h0, NOP});
    cyc();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    chk("idle_req", bus.imem_req, 0);
    chk("idle_ce", bus.ifid_ce, 0);
    cyc();
    chk("fetch0_req", bus.imem_req, 1);
    chk("fetch0_addr", bus.imem_addr, 64'h0);

    // zero-wait stream
    drive(0, 0, 0, 1, 32'hA000_0000);
    chk("zw0_ce", bus.ifid_ce, 1);
    chk("zw0_data", bus.ifid_data, 64'h00000000_A0000000);
    cyc();
    drive(0, 0, 0, 1, 32'hA000_0004);
    chk("zw1_addr", bus.imem_addr, 64'h4);
    chk("zw1_data", bus.ifid_data, 64'h00000004_A0000004);
    chk("zw1_ce", bus.ifid_ce, 1);
    cyc();

    // stall in the response cycle for addr 0x8, held in HOLD for 3 cycles
    drive(1, 0, 0, 1, 32'h1234_5678);
    chk("st_addr", bus.imem_addr, 64'h8);
    chk("st_ce", bus.ifid_ce, 0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 32'hFFFF_FFFF);
      chk("hold_req", bus.imem_req, 0);
      chk("hold_ce", bus.ifid_ce, 0);
      cyc();
    end
    drive(0, 0, 0, 0, 0);
    chk("rel_ce", bus.ifid_ce, 1);
    chk("rel_data", bus.ifid_data, 64'h00000008_12345678);
    cyc();
    chk("rel_next_addr", bus.imem_addr, 64'hC);
    chk("rel_next_req", bus.imem_req, 1);

    // advance to 0x10, then redirect while its response is late
    drive(0, 0, 0, 1, 32'hA000_000C);
    chk("c_data", bus.ifid_data, 64'h0000000C_A000000C);
    cyc();
    drive(0, 0, 0, 0, 0);
    chk("wait_ce", bus.ifid_ce, 0);
    chk("wait_addr", bus.imem_addr, 64'h10);
    cyc();
    drive(0, 1, 32'h0000_0103, 0, 0);
    chk("redir_ce", bus.ifid_ce, 1);
    chk("redir_data", bus.ifid_data, 64'h00000010_00000013);
    cyc();
    drive(0, 0, 0, 0, 0);
    chk("drop_req", bus.imem_req, 0);
    chk("drop_ce", bus.ifid_ce, 0);
    cyc();
    drive(0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("stale_ce", bus.ifid_ce, 0);
    chk("stale_req", bus.imem_req, 0);
    cyc();
    drive(0, 0, 0, 0, 0);
    chk("post_drop_addr", bus.imem_addr, 64'h100);
    chk("post_drop_req", bus.imem_req, 1);

    // redirect together with stall while in HOLD
    drive(1, 0, 0, 1, 32'h1111_1111);
    chk("h2_ce", bus.ifid_ce, 0);
    cyc();
    drive(1, 1, 32'h0000_0200, 0, 0);
    chk("hr_ce", bus.ifid_ce, 1);
    chk("hr_data", bus.ifid_data, {32'h100, NOP});
    cyc();
    drive(0, 0, 0, 0, 0);
    chk("hr_next_addr", bus.imem_addr, 64'h200);
    chk("hr_next_req", bus.imem_req, 1);

    // redirect coinciding with a zero-wait response, then PC wrap
    drive(0, 1, 32'hFFFF_FFFF, 1, 32'h7777_7777);
    chk("rz_data", bus.ifid_data, {32'h200, NOP});
    cyc();
    drive(0, 0, 0, 1, 32'hCAFE_F00D);
    chk("top_addr", bus.imem_addr, 64'hFFFF_FFFC);
    chk("top_req", bus.imem_req, 1);
    chk("top_data", bus.ifid_data, 64'hFFFFFFFC_CAFEF00D);
    cyc();
    drive(0, 0, 0, 0, 0);
    chk("wrap_addr", bus.imem_addr, 64'h0);

    // stall with no response must not advance the PC
    drive(1, 0, 0, 0, 0);
    chk("st_nr_ce", bus.ifid_ce, 0);
    cyc();
    drive(0, 0, 0, 0, 0);
    chk("st_nr_addr", bus.imem_addr, 64'h0);

    // reset while in DROP
    drive(0, 1, 32'h0000_0040, 0, 0);
    chk("d2_ce", bus.ifid_ce, 1);
    cyc();
    rst_n = 1'b0;
    drive(0, 0, 0, 1, 32'h5555_5555);
    chk("rd_ce", bus.ifid_ce, 0);
    chk("rd_req", bus.imem_req, 0);
    cyc();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    chk("rd_idle_req", bus.imem_req, 0);
    chk("rd_idle_ce", bus.ifid_ce, 0);
    chk("rd_idle_data", bus.ifid_data, {32'h0, NOP});
    cyc();
    chk("rd_fetch_req", bus.imem_req, 1);
    chk("rd_fetch_addr", bus.imem_addr, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
